// File: rtl/mb_debug_axil_regs.sv
// AXI4-Lite register file for MB_Debug: NUM_REGS read/write words exported on reg_out,
// with a one-cycle write strobe per register and SLVERR for out-of-range offsets.
module mb_debug_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int NUM_REGS           = 4
) (
    input  logic                               ACLK,
    input  logic                               ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_AWADDR,
    input  logic [2:0]                         S_AXI_AWPROT,
    input  logic                               S_AXI_AWVALID,
    output logic                               S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]    S_AXI_WSTRB,
    input  logic                               S_AXI_WVALID,
    output logic                               S_AXI_WREADY,
    output logic [1:0]                         S_AXI_BRESP,
    output logic                               S_AXI_BVALID,
    input  logic                               S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_ARADDR,
    input  logic [2:0]                         S_AXI_ARPROT,
    input  logic                               S_AXI_ARVALID,
    output logic                               S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_RDATA,
    output logic [1:0]                         S_AXI_RRESP,
    output logic                               S_AXI_RVALID,
    input  logic                               S_AXI_RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]                reg_wr_pulse
);
    localparam int DW     = C_S_AXI_DATA_WIDTH;
    localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
    localparam int STRB_W = DW / 8;
    localparam logic [IDX_W:0] NUM_REGS_L = (IDX_W + 1)'(NUM_REGS);

    typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [DW-1:0]     regs [NUM_REGS];
    logic [IDX_W-1:0]  aw_idx_q;
    logic [DW-1:0]     wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic              aw_done, w_done;
    logic              awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
    logic [1:0]        bresp_q, rresp_q;
    logic [DW-1:0]     rdata_q, rd_word;
    logic [NUM_REGS-1:0] pulse_q;
    logic              aw_hs, w_hs, ar_hs, wr_in_range, rd_in_range;
    logic [IDX_W-1:0]  rd_idx;
    logic              unused_ok;

    assign aw_hs       = S_AXI_AWVALID & awready_q;
    assign w_hs        = S_AXI_WVALID & wready_q;
    assign ar_hs       = S_AXI_ARVALID & arready_q;
    assign rd_idx      = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign wr_in_range = {1'b0, aw_idx_q} < NUM_REGS_L;
    assign rd_in_range = {1'b0, rd_idx} < NUM_REGS_L;
    assign unused_ok   = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // ---------------- write channel ----------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) w_state <= W_IDLE;
        else          w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:   if (aw_done && w_done) w_next = W_COMMIT;
            W_COMMIT: w_next = W_RESP;
            W_RESP:   if (S_AXI_BREADY) w_next = W_IDLE;
            default:  w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_idx_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            pulse_q   <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            pulse_q <= '0;
            case (w_state)
                W_IDLE: begin
                    // AW and W are captured independently; each READY drops once its beat is held
                    if (aw_hs) begin
                        aw_idx_q  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
                        aw_done   <= 1'b1;
                        awready_q <= 1'b0;
                    end else if (!aw_done) begin
                        awready_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wdata_q  <= S_AXI_WDATA;
                        wstrb_q  <= S_AXI_WSTRB;
                        w_done   <= 1'b1;
                        wready_q <= 1'b0;
                    end else if (!w_done) begin
                        wready_q <= 1'b1;
                    end
                end
                W_COMMIT: begin
                    bvalid_q <= 1'b1;
                    if (wr_in_range) begin
                        bresp_q <= 2'b00;
                        for (int unsigned i = 0; i < NUM_REGS; i++) begin
                            if (aw_idx_q == IDX_W'(i)) begin
                                pulse_q[i] <= 1'b1;
                                for (int unsigned b = 0; b < STRB_W; b++)
                                    if (wstrb_q[b]) regs[i][8*b +: 8] <= wdata_q[8*b +: 8];
                            end
                        end
                    end else begin
                        bresp_q <= 2'b10;
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- read channel ----------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) r_state <= R_IDLE;
        else          r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_RESP;
            R_RESP:  if (S_AXI_RREADY) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        rd_word = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++)
            if (rd_idx == IDX_W'(i)) rd_word = regs[i];
    end

    // Sampling regs here on the commit edge naturally returns the pre-write value
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        rdata_q   <= rd_in_range ? rd_word : '0;
                        rresp_q   <= rd_in_range ? 2'b00 : 2'b10;
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_RESP: begin
                    if (S_AXI_RREADY) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        reg_out = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) reg_out[DW*i +: DW] = regs[i];
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign reg_wr_pulse  = pulse_q;

endmodule

// File: tb/tb_mb_debug_axil_regs.sv
// Scoreboard bench for mb_debug_axil_regs: drivers queue expected B/R responses,
// monitors pop and compare whenever a response handshake occurs.
module tb_mb_debug_axil_regs;
    logic         ACLK = 1'b0;
    logic         ARESETN;
    logic [4:0]   S_AXI_AWADDR, S_AXI_ARADDR;
    logic [2:0]   S_AXI_AWPROT, S_AXI_ARPROT;
    logic         S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
    logic [31:0]  S_AXI_WDATA, S_AXI_RDATA;
    logic [3:0]   S_AXI_WSTRB;
    logic [1:0]   S_AXI_BRESP, S_AXI_RRESP;
    logic         S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
    logic         S_AXI_RVALID, S_AXI_RREADY;
    logic [127:0] reg_out;
    logic [3:0]   reg_wr_pulse;

    mb_debug_axil_regs #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(5),
        .NUM_REGS(4)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
    );

    always #5 ACLK = ~ACLK;

    typedef struct { logic [1:0] resp; logic [3:0] pulse; } b_exp_t;
    typedef struct { logic [31:0] data; logic [1:0] resp; } r_exp_t;
    b_exp_t bq[$];
    r_exp_t rq[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got timeout/unexpected event, expected handshake (t=%0t)", name, $time);
    endtask

    function automatic logic sig_sel(input int which);
        case (which)
            0:       return S_AXI_BVALID;
            1:       return S_AXI_RVALID;
            2:       return S_AXI_BVALID && S_AXI_BREADY;
            default: return S_AXI_RVALID && S_AXI_RREADY;
        endcase
    endfunction

    // Returns at the negedge where the selected condition is first seen
    task automatic wait_high(input int which, input string name);
        bit got = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge ACLK);
            if (sig_sel(which)) begin got = 1; break; end
        end
        if (!got) flag_fail(name);
    endtask

    task automatic do_aw_w(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit aw_ok = 0, w_ok = 0, a, w;
        S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = data;  S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
        for (int k = 0; k < 40 && !(aw_ok && w_ok); k++) begin
            @(negedge ACLK);
            a = S_AXI_AWVALID && S_AXI_AWREADY;
            w = S_AXI_WVALID && S_AXI_WREADY;
            @(posedge ACLK); #1;
            if (a) begin S_AXI_AWVALID = 1'b0; aw_ok = 1; end
            if (w) begin S_AXI_WVALID = 1'b0; w_ok = 1; end
        end
        if (!(aw_ok && w_ok)) begin
            flag_fail("aw_w_handshake");
            S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        end
    endtask

    task automatic do_ar(input logic [4:0] addr);
        bit ok = 0, a;
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge ACLK);
            a = S_AXI_ARVALID && S_AXI_ARREADY;
            @(posedge ACLK); #1;
            if (a) begin S_AXI_ARVALID = 1'b0; ok = 1; end
        end
        if (!ok) begin flag_fail("ar_handshake"); S_AXI_ARVALID = 1'b0; end
    endtask

    task automatic write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                         input logic [1:0] resp, input logic [3:0] pulse);
        b_exp_t e;
        e.resp = resp; e.pulse = pulse;
        bq.push_back(e);
        S_AXI_BREADY = 1'b1;
        do_aw_w(addr, data, strb);
        wait_high(2, "b_handshake");
        @(posedge ACLK); #1;
    endtask

    task automatic read(input logic [4:0] addr, input logic [31:0] data, input logic [1:0] resp);
        r_exp_t e;
        e.data = data; e.resp = resp;
        rq.push_back(e);
        S_AXI_RREADY = 1'b1;
        do_ar(addr);
        wait_high(3, "r_handshake");
        @(posedge ACLK); #1;
    endtask

    // B monitor: write strobes are accumulated over each transaction
    logic [3:0] pacc;
    int         pcnt;
    always @(negedge ACLK) begin
        b_exp_t be;
        if (!ARESETN) begin
            pacc = '0; pcnt = 0;
        end else begin
            pacc = pacc | reg_wr_pulse;
            if (|reg_wr_pulse) pcnt++;
            if (S_AXI_BVALID && S_AXI_BREADY) begin
                if (bq.size() == 0) flag_fail("b_unexpected");
                else begin
                    be = bq.pop_front();
                    check("bresp", S_AXI_BRESP, be.resp);
                    check("wr_pulse", pacc, be.pulse);
                    check("wr_pulse_len", pcnt, (be.pulse != 0) ? 1 : 0);
                end
                pacc = '0; pcnt = 0;
            end
        end
    end

    always @(negedge ACLK) begin
        r_exp_t re;
        if (ARESETN && S_AXI_RVALID && S_AXI_RREADY) begin
            if (rq.size() == 0) flag_fail("r_unexpected");
            else begin
                re = rq.pop_front();
                check("rdata", S_AXI_RDATA, re.data);
                check("rresp", S_AXI_RRESP, re.resp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        b_exp_t e;
        ARESETN = 1'b0;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;

        // reset state
        repeat (2) @(negedge ACLK);
        check("rst_awready", S_AXI_AWREADY, 0);
        check("rst_wready", S_AXI_WREADY, 0);
        check("rst_arready", S_AXI_ARREADY, 0);
        check("rst_bvalid", S_AXI_BVALID, 0);
        check("rst_rvalid", S_AXI_RVALID, 0);
        check("rst_rdata", S_AXI_RDATA, 0);
        check("rst_reg_out", reg_out, 0);
        check("rst_pulse", reg_wr_pulse, 0);
        ARESETN = 1'b1;
        @(negedge ACLK);
        check("post_rst_readys", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
        @(posedge ACLK); #1;

        // four full-word writes and read-back
        write(5'h00, 32'h1, 4'hF, 2'b00, 4'b0001);
        write(5'h04, 32'h2, 4'hF, 2'b00, 4'b0010);
        write(5'h08, 32'h3, 4'hF, 2'b00, 4'b0100);
        write(5'h0C, 32'h4, 4'hF, 2'b00, 4'b1000);
        check("reg_out_4w", reg_out, 128'h00000004_00000003_00000002_00000001);
        read(5'h00, 32'h1, 2'b00);
        read(5'h04, 32'h2, 2'b00);
        read(5'h08, 32'h3, 2'b00);
        read(5'h0C, 32'h4, 2'b00);

        // byte strobes, unaligned read address
        write(5'h04, 32'hAABBCCDD, 4'hF, 2'b00, 4'b0010);
        write(5'h04, 32'h11223344, 4'b0101, 2'b00, 4'b0010);
        read(5'h04, 32'hAA22CC44, 2'b00);
        read(5'h07, 32'hAA22CC44, 2'b00);

        // AW three cycles ahead of W, B stalled
        e.resp = 2'b00; e.pulse = 4'b0100;
        bq.push_back(e);
        S_AXI_BREADY = 1'b0;
        S_AXI_AWADDR = 5'h08; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h55667788; S_AXI_WSTRB = 4'hF;
        @(negedge ACLK);
        check("aw_first_ready", S_AXI_AWREADY, 1);
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0;
        @(negedge ACLK);
        check("aw_held_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID}, 3'b010);
        @(posedge ACLK); #1;
        @(posedge ACLK); #1;
        S_AXI_WVALID = 1'b1;
        @(negedge ACLK);
        check("w_late_ready", S_AXI_WREADY, 1);
        @(posedge ACLK); #1;
        S_AXI_WVALID = 1'b0;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge ACLK);
            if (S_AXI_BVALID) break;
            @(posedge ACLK);
            n++;
        end
        check("b_latency", n, 2);
        repeat (5) begin
            @(negedge ACLK);
            check("b_stall", {S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, S_AXI_WREADY}, 5'b10000);
        end
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b1;
        wait_high(2, "b_handshake_stall");
        @(posedge ACLK); #1;
        @(negedge ACLK);
        check("readys_after_b", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
        @(posedge ACLK); #1;

        // out-of-range write and read
        write(5'h10, 32'h0000DEAD, 4'hF, 2'b10, 4'b0000);
        check("reg_out_oor", reg_out, 128'h00000004_55667788_AA22CC44_00000001);
        read(5'h1C, 32'h0, 2'b10);

        // stalled read in parallel with a write
        fork
            begin
                r_exp_t re;
                re.data = 32'h55667788; re.resp = 2'b00;
                rq.push_back(re);
                S_AXI_RREADY = 1'b0;
                do_ar(5'h08);
                wait_high(1, "rvalid_stall");
                repeat (4) begin
                    check("r_stall", {S_AXI_RVALID, S_AXI_ARREADY, S_AXI_RRESP, S_AXI_RDATA},
                          {1'b1, 1'b0, 2'b00, 32'h55667788});
                    @(negedge ACLK);
                end
                @(posedge ACLK); #1;
                S_AXI_RREADY = 1'b1;
                wait_high(3, "r_handshake_stall");
                @(posedge ACLK); #1;
            end
            write(5'h00, 32'h12345678, 4'hF, 2'b00, 4'b0001);
        join
        check("reg_out_par", reg_out, 128'h00000004_55667788_AA22CC44_12345678);

        // reset while both response channels are pending
        S_AXI_BREADY = 1'b0;
        S_AXI_RREADY = 1'b0;
        do_aw_w(5'h0C, 32'hCAFEF00D, 4'hF);
        wait_high(0, "bvalid_pre_rst");
        @(posedge ACLK); #1;
        do_ar(5'h00);
        wait_high(1, "rvalid_pre_rst");
        @(posedge ACLK); #1;
        ARESETN = 1'b0;
        #1;
        check("mid_rst_valids", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
        check("mid_rst_readys", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
        check("mid_rst_reg_out", reg_out, 0);
        check("mid_rst_rdata", S_AXI_RDATA, 0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        check("mid_rst_readys_back", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
        @(posedge ACLK); #1;
        read(5'h00, 32'h0, 2'b00);

        repeat (2) @(negedge ACLK);
        check("bq_drained", bq.size(), 0);
        check("rq_drained", rq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
